perm_table: RTL and testbench
=============================

# perm_table

Programmable W-bit substitution/permutation table with forward and inverse lookup. It generalises the fixed 4-bit combinational lookup to any symbol width and makes the contents reprogrammable at run time. Contents are modified only by swap operations, so the table is always a valid permutation and the inverse table is always consistent with it. The block sits in the datapath wherever a keyed or reconfigurable substitution stage is needed. It replaces hard-coded case tables.

## Interface
- W, default 4: symbol width; table depth is 2^W entries (legal 2..8).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  lookup request.
- rd_inv  in  1  0 = forward lookup, 1 = inverse lookup; sampled with rd_en.
- rd_addr  in  W  lookup index.
- rd_valid  out  1  one-cycle pulse: rd_data holds the result of a request.
- rd_data  out  W  lookup result; holds its last value when rd_valid = 0.
- sw_en  in  1  swap request.
- sw_a  in  W  first swap index.
- sw_b  in  W  second swap index.
- sw_ack  out  1  one-cycle pulse: the swap was accepted and applied.
- ready  out  1  1 = table initialised; lookups and swaps are accepted.

## Operation
- Storage:
  - fwd[0..2^W-1] and inv[0..2^W-1], W bits each, held in flip-flop arrays.
  - Invariant: inv[fwd[i]] == i for all i.
- Table contents are not cleared by the asynchronous reset. They are initialised by the INIT state.
- FSM has two states, INIT and RUN.
- Reset (rst_n = 0), taking effect immediately:
  - state = INIT, init counter cnt = 0.
  - ready = 0, rd_valid = 0, rd_data = 0, sw_ack = 0.
- INIT:
  - Each rising edge writes fwd[cnt] = cnt and inv[cnt] = cnt, then increments cnt.
  - The edge that writes entry 2^W-1 also moves the FSM to RUN and sets ready = 1.
  - The counter is W+1 bits wide, or uses an explicit last-entry compare, so it cannot wrap before the transition.
- In INIT, rd_en and sw_en are ignored: no rd_valid, no sw_ack, no table change.
- RUN:
  - No transition out of RUN except through reset.
  - Lookup: when rd_en = 1, the next edge sets rd_data = rd_inv ? inv[rd_addr] : fwd[rd_addr] and rd_valid = 1.
  - Swap: when sw_en = 1, the next edge applies the following, all from pre-edge values:
    - Let x = fwd[sw_a] and y = fwd[sw_b].
    - fwd[sw_a] <= y, fwd[sw_b] <= x.
    - inv[y] <= sw_a, inv[x] <= sw_b.
    - sw_ack = 1.
  - Swap with sw_a == sw_b: table unchanged; sw_ack still pulses.
- Simultaneous lookup and swap in the same cycle: both are accepted. The lookup returns the pre-swap contents. The swap is visible to lookups issued from the next cycle on.
- Back-to-back operations: one lookup and one swap per cycle, sustained. There is no stall or backpressure in RUN.
- Reset asserted mid-operation:
  - Any in-flight rd_valid or sw_ack is cleared immediately.
  - All prior swaps are discarded, because INIT rewrites identity.

## Timing
- Lookup latency is 1 cycle: request at edge N gives rd_valid and rd_data after edge N+1.
- Swap latency is 1 cycle: sw_ack after edge N+1, and the new contents are readable by a request at edge N+1.
- After rst_n deasserts, ready rises after the 2^W-th rising edge (16 edges for W = 4).
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Reset then idle, W = 4:
  - Required: ready = 0 for exactly 16 edges, then 1.
  - Then rd_en with rd_addr = 5, rd_inv = 0 → rd_valid one cycle later with rd_data = 5. rd_inv = 1 also gives 5.
- Swap sw_a = 3, sw_b = 12 → sw_ack pulse. Required: fwd[3] = 12, fwd[12] = 3, inv[12] = 3, inv[3] = 12; fwd[0] = 0 unaffected.
- Program the legacy map (0→0, 1→6, 2→3, 3→14, 4→11, 5→15, 6→7, 7→12, 8→1, 9→5, 10→13, 11→10, 12→2, 13→4, 14→8, 15→9) using a selection-sort swap sequence.
  - Required: all 16 forward reads match the map.
  - Required: inverse reads satisfy inv[6] = 1, inv[9] = 15 and the full invariant.
- Same-cycle operations: rd_addr = 3 with a swap of 3↔7 (from identity) → rd_data = 3; the next-cycle read of 3 → 7. Swap 9↔9 → sw_ack = 1, no table change.
- Requests during INIT: rd_en and sw_en asserted during INIT → no rd_valid, no sw_ack, and identity holds after ready.
- Reset mid-run: pulse rst_n low after several swaps, including while rd_en = 1 → rd_valid drops immediately, ready is low for 16 edges, and the table reads back as identity.

Source files
------------

// File: rtl/perm_table.sv
// Reprogrammable W-bit permutation table with forward/inverse lookup.
// Contents change only through swaps, so fwd and inv stay mutually consistent.
module perm_table #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd_en_i,
    input  logic         rd_inv_i,
    input  logic [W-1:0] rd_addr_i,
    output logic         rd_valid_o,
    output logic [W-1:0] rd_data_o,
    input  logic         sw_en_i,
    input  logic [W-1:0] sw_a_i,
    input  logic [W-1:0] sw_b_i,
    output logic         sw_ack_o,
    output logic         ready_o
);

    localparam int unsigned DEPTH = 1 << W;
    localparam int unsigned CW    = W + 1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   fwd_q [DEPTH];
    logic [W-1:0]   inv_q [DEPTH];

    logic [W-1:0]   sw_x_c;
    logic [W-1:0]   sw_y_c;
    logic [W-1:0]   init_idx_c;
    logic           last_c;

    assign sw_x_c     = fwd_q[sw_a_i];
    assign sw_y_c     = fwd_q[sw_b_i];
    assign init_idx_c = cnt_q[W-1:0];
    assign last_c     = (cnt_q == CW'(DEPTH - 1));

    // Control FSM and registered outputs; extra counter bit prevents wrap before RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            ready_o    <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            sw_ack_o   <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            sw_ack_o   <= 1'b0;
            case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (last_c) begin
                        state_q <= S_RUN;
                        ready_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (rd_en_i) begin
                        rd_valid_o <= 1'b1;
                        rd_data_o  <= rd_inv_i ? inv_q[rd_addr_i] : fwd_q[rd_addr_i];
                    end
                    sw_ack_o <= sw_en_i;
                end
            endcase
        end
    end

    // Table storage is deliberately not reset; INIT rewrites identity instead.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            fwd_q[init_idx_c] <= init_idx_c;
            inv_q[init_idx_c] <= init_idx_c;
        end else if (sw_en_i) begin
            fwd_q[sw_a_i] <= sw_y_c;
            fwd_q[sw_b_i] <= sw_x_c;
            inv_q[sw_y_c] <= sw_a_i;
            inv_q[sw_x_c] <= sw_b_i;
        end
    end

endmodule

// File: tb/tb_perm_table.sv
// Bench for perm_table (W=4): scoreboard of lookup results and swap acks,
// table-driven checks of a programmed legacy map, and reset/INIT corner cases.
module tb_perm_table;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_en = 1'b0;
    logic       rd_inv = 1'b0;
    logic [3:0] rd_addr = '0;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic       sw_en = 1'b0;
    logic [3:0] sw_a = '0;
    logic [3:0] sw_b = '0;
    logic       sw_ack;
    logic       ready;

    perm_table #(.W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en_i    (rd_en),
        .rd_inv_i   (rd_inv),
        .rd_addr_i  (rd_addr),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .sw_en_i    (sw_en),
        .sw_a_i     (sw_a),
        .sw_b_i     (sw_b),
        .sw_ack_o   (sw_ack),
        .ready_o    (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [3:0] data;
    } rd_exp_t;

    typedef struct {
        bit         inv;
        logic [3:0] addr;
        logic [3:0] exp;
    } vec_t;

    rd_exp_t    rd_q[$];
    int         ack_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] mf [16];
    logic [3:0] mi [16];
    logic [3:0] legacy [16] = '{4'd0, 4'd6, 4'd3, 4'd14, 4'd11, 4'd15, 4'd7, 4'd12,
                                4'd1, 4'd5, 4'd13, 4'd10, 4'd2, 4'd4, 4'd8, 4'd9};
    vec_t       vecs[$];

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every observed rd_valid/sw_ack must match a pushed expectation, and vice versa.
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_rd;
            bit exp_ack;
            exp_rd  = (rd_q.size() > 0) && (rd_q[0].due == cyc);
            exp_ack = (ack_q.size() > 0) && (ack_q[0] == cyc);
            if (exp_rd || rd_valid) begin
                n_cmp++;
                if (!exp_rd) begin
                    n_bad++;
                    $display("FAIL rd_unexpected: rd_valid=%0d data=%0d expected no response", rd_valid, rd_data);
                end else if (!rd_valid || rd_data !== rd_q[0].data) begin
                    n_bad++;
                    $display("FAIL rd_data: valid=%0d data=%0d expected valid=1 data=%0d (cyc %0d)",
                             rd_valid, rd_data, rd_q[0].data, cyc);
                end
                if (exp_rd) void'(rd_q.pop_front());
            end
            if (exp_ack || sw_ack) begin
                n_cmp++;
                if (exp_ack != sw_ack) begin
                    n_bad++;
                    $display("FAIL sw_ack: got %0d expected %0d (cyc %0d)", sw_ack, exp_ack, cyc);
                end
                if (exp_ack) void'(ack_q.pop_front());
            end
        end
    end

    task automatic model_ident();
        for (int i = 0; i < 16; i++) begin
            mf[i] = 4'(i);
            mi[i] = 4'(i);
        end
    endtask

    task automatic model_swap(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x;
        logic [3:0] y;
        x = mf[a];
        y = mf[b];
        mf[a] = y;
        mf[b] = x;
        mi[y] = a;
        mi[x] = b;
    endtask

    // One RUN cycle; exp >= 0 gives a fixed expected read value, else the model supplies it.
    task automatic op(input bit rd, input bit inv, input logic [3:0] addr,
                      input bit sw, input logic [3:0] a, input logic [3:0] b, input int exp);
        rd_exp_t e;
        rd_en = rd; rd_inv = inv; rd_addr = addr;
        sw_en = sw; sw_a = a; sw_b = b;
        if (rd) begin
            e.due  = cyc + 1;
            e.data = (exp >= 0) ? 4'(exp) : (inv ? mi[addr] : mf[addr]);
            rd_q.push_back(e);
        end
        if (sw) begin
            ack_q.push_back(cyc + 1);
            model_swap(a, b);
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        sw_en = 1'b0;
    endtask

    // Assert reset now, hold requests active through reset and INIT, and time the ready rise.
    task automatic do_reset();
        rd_en = 1'b1; sw_en = 1'b1; sw_a = 4'd1; sw_b = 4'd2; rd_addr = 4'd1;
        rst_n = 1'b0;
        rd_q.delete();
        ack_q.delete();
        #1;
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_sw_ack", int'(sw_ack), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            sw_a = 4'($urandom_range(0, 15));
            sw_b = 4'($urandom_range(0, 15));
            rd_inv = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk($sformatf("init_ready_e%0d", e), int'(ready), (e == 16) ? 1 : 0);
            chk("init_rd_valid", int'(rd_valid), 0);
            chk("init_sw_ack", int'(sw_ack), 0);
        end
        rd_en = 1'b0;
        sw_en = 1'b0;
        model_ident();
    endtask

    task automatic check_identity();
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b0, 4'(i), 1'b0, 4'd0, 4'd0, i);
            op(1'b1, 1'b1, 4'(i), 1'b0, 4'd0, 4'd0, i);
        end
    endtask

    initial begin
        model_ident();
        @(posedge clk); #1;
        do_reset();
        check_identity();

        op(1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 4'd0, 5);
        op(1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 4'd0, 5);

        op(1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd12, -1);
        op(1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 4'd0, 12);
        op(1'b1, 1'b0, 4'd12, 1'b0, 4'd0, 4'd0, 3);
        op(1'b1, 1'b1, 4'd12, 1'b0, 4'd0, 4'd0, 3);
        op(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 12);
        op(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 0);

        // A few back-to-back swaps with reads, then reset while a read is in flight.
        op(1'b1, 1'b0, 4'd1, 1'b1, 4'd1, 4'd2, -1);
        op(1'b1, 1'b1, 4'd2, 1'b1, 4'd2, 4'd5, -1);
        op(1'b1, 1'b0, 4'd5, 1'b1, 4'd0, 4'd15, -1);
        rd_en = 1'b1; rd_inv = 1'b0; rd_addr = 4'd15;
        rd_q.push_back('{due: cyc + 1, data: mf[15]});
        @(posedge clk); #1;
        chk("pre_rst_rd_valid", int'(rd_valid), 1);
        chk("pre_rst_rd_data", int'(rd_data), 0);
        do_reset();
        check_identity();

        // Same-cycle read and swap: read sees pre-swap contents.
        op(1'b1, 1'b0, 4'd3, 1'b1, 4'd3, 4'd7, 3);
        op(1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 4'd0, 7);
        op(1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 3);
        op(1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd9, -1);
        op(1'b1, 1'b0, 4'd9, 1'b0, 4'd0, 4'd0, 9);
        op(1'b1, 1'b1, 4'd9, 1'b0, 4'd0, 4'd0, 9);

        // Program the legacy map by selection sort from the current contents.
        for (int i = 0; i < 16; i++) begin
            int j;
            j = i;
            for (int k = i; k < 16; k++) if (mf[k] == legacy[i]) j = k;
            if (j != i) op(1'b0, 1'b0, 4'd0, 1'b1, 4'(i), 4'(j), -1);
        end

        for (int i = 0; i < 16; i++) vecs.push_back('{inv: 1'b0, addr: 4'(i), exp: legacy[i]});
        vecs.push_back('{inv: 1'b1, addr: 4'd6, exp: 4'd1});
        vecs.push_back('{inv: 1'b1, addr: 4'd9, exp: 4'd15});
        for (int i = 0; i < 16; i++) vecs.push_back('{inv: 1'b1, addr: legacy[i], exp: 4'(i)});
        foreach (vecs[n]) op(1'b1, vecs[n].inv, vecs[n].addr, 1'b0, 4'd0, 4'd0, int'(vecs[n].exp));

        repeat (3) @(posedge clk);
        #1;
        chk("drain_rd_q", rd_q.size(), 0);
        chk("drain_ack_q", ack_q.size(), 0);
        chk("final_ready", int'(ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
